// File: rtl/hamming_best_match.sv
// Streaming brute-force descriptor matcher.
// One query descriptor is compared against a framed burst of candidates,
// one candidate per cycle. A three-stage pipeline computes the Hamming
// distance (XOR + popcount), tracks the best and second-best distances
// over the frame, and emits one result per frame with an accept flag
// derived from a distance threshold and a distinctiveness margin.
module hamming_best_match #(
  parameter int DESC_W = 256,
  parameter int IDX_W  = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic                         i_first,
  input  logic                         i_last,
  input  logic [DESC_W-1:0]            i_src_desc,
  input  logic [DESC_W-1:0]            i_dst_desc,
  input  logic [IDX_W-1:0]             i_dst_idx,
  input  logic [$clog2(DESC_W):0]      i_max_dist,
  input  logic [$clog2(DESC_W):0]      i_min_margin,
  output logic                         o_valid,
  output logic                         o_match,
  output logic [IDX_W-1:0]             o_best_idx,
  output logic [$clog2(DESC_W):0]      o_best_dist,
  output logic [$clog2(DESC_W):0]      o_second_dist,
  output logic                         o_drop
);

  localparam int DIST_W  = $clog2(DESC_W) + 1;
  localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};
  // The first stage reduces the XOR vector to this many partial sums.
  localparam int N_PART  = 8;
  localparam int CHUNK_W = DESC_W / N_PART;
  // A chunk of CHUNK_W bits can hold up to CHUNK_W ones, so each partial
  // sum is one bit wider than log2 of the chunk; the final sum widens to
  // DIST_W so the full 0..DESC_W range fits.
  localparam int PART_W  = $clog2(CHUNK_W) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  // Count of ones within one chunk of the XOR vector.
  function automatic logic [PART_W-1:0] popcount_chunk(input logic [CHUNK_W-1:0] bits);
    logic [PART_W-1:0] acc;
    acc = {PART_W{1'b0}};
    for (int k = 0; k < CHUNK_W; k++) begin
      acc = acc + PART_W'(bits[k]);
    end
    return acc;
  endfunction

  // Final reduction of the partial sums into a full distance.
  function automatic logic [DIST_W-1:0] sum_parts(input logic [N_PART-1:0][PART_W-1:0] parts);
    logic [DIST_W-1:0] acc;
    acc = {DIST_W{1'b0}};
    for (int k = 0; k < N_PART; k++) begin
      acc = acc + DIST_W'(parts[k]);
    end
    return acc;
  endfunction

  // Frame state and source latch
  state_t                          state_q, state_d;
  logic [DESC_W-1:0]               src_q, src_d;
  logic [DESC_W-1:0]               src_sel_s;
  logic [DESC_W-1:0]               xor_s;
  logic                            acc_s;
  logic                            drop_s;

  // Stage 1 registers
  logic                            s1_valid_q, s1_valid_d;
  logic [N_PART-1:0][PART_W-1:0]   s1_part_q, s1_part_d;
  logic [IDX_W-1:0]                s1_idx_q, s1_idx_d;
  logic                            s1_first_q, s1_first_d;
  logic                            s1_last_q, s1_last_d;
  logic [DIST_W-1:0]               s1_max_q, s1_max_d;
  logic [DIST_W-1:0]               s1_margin_q, s1_margin_d;

  // Stage 2 registers
  logic                            s2_valid_q, s2_valid_d;
  logic [DIST_W-1:0]               s2_dist_q, s2_dist_d;
  logic [IDX_W-1:0]                s2_idx_q, s2_idx_d;
  logic                            s2_first_q, s2_first_d;
  logic                            s2_last_q, s2_last_d;
  logic [DIST_W-1:0]               s2_max_q, s2_max_d;
  logic [DIST_W-1:0]               s2_margin_q, s2_margin_d;

  // Stage 3 tracker and result registers
  logic [DIST_W-1:0]               best_q, best_d;
  logic [DIST_W-1:0]               second_q, second_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [DIST_W-1:0]               trk_best_s;
  logic [DIST_W-1:0]               trk_second_s;
  logic [IDX_W-1:0]                trk_idx_s;
  logic [DIST_W-1:0]               margin_s;
  logic                            valid_q, valid_d;
  logic                            match_q, match_d;
  logic [IDX_W-1:0]                out_idx_q, out_idx_d;
  logic [DIST_W-1:0]               out_best_q, out_best_d;
  logic [DIST_W-1:0]               out_second_q, out_second_d;
  logic                            drop_q, drop_d;

  // Frame FSM: decide whether the current beat enters the pipeline or is dropped.
  always_comb begin
    state_d = state_q;
    acc_s   = 1'b0;
    drop_s  = 1'b0;
    if (i_valid) begin
      if (i_first) begin
        // A first beat always starts a frame; one arriving while a frame
        // is open abandons that frame, which is reported as a drop.
        acc_s   = 1'b1;
        drop_s  = (state_q == ST_OPEN);
        state_d = i_last ? ST_IDLE : ST_OPEN;
      end else if (state_q == ST_OPEN) begin
        acc_s   = 1'b1;
        drop_s  = 1'b0;
        state_d = i_last ? ST_IDLE : ST_OPEN;
      end else begin
        acc_s   = 1'b0;
        drop_s  = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Stage 1 inputs: source select, XOR and per-chunk popcount.
  always_comb begin
    // The first beat of a frame must use the live query, since the latch
    // only captures it at the end of that cycle.
    if (i_valid && i_first) begin
      src_sel_s = i_src_desc;
    end else begin
      src_sel_s = src_q;
    end
    src_d = src_sel_s;
    xor_s = src_sel_s ^ i_dst_desc;
    s1_part_d = '0;
    for (int k = 0; k < N_PART; k++) begin
      s1_part_d[k] = popcount_chunk(xor_s[k*CHUNK_W +: CHUNK_W]);
    end
    s1_valid_d  = acc_s;
    s1_idx_d    = i_dst_idx;
    s1_first_d  = i_first;
    s1_last_d   = i_last;
    s1_max_d    = i_max_dist;
    s1_margin_d = i_min_margin;
  end

  // Stage 2 inputs: final distance sum and tag forwarding.
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_dist_d   = sum_parts(s1_part_q);
    s2_idx_d    = s1_idx_q;
    s2_first_d  = s1_first_q;
    s2_last_d   = s1_last_q;
    s2_max_d    = s1_max_q;
    s2_margin_d = s1_margin_q;
  end

  // Stage 3 tracker: best/second-best update with strict comparisons so ties keep the earlier index.
  always_comb begin
    trk_best_s   = best_q;
    trk_second_s = second_q;
    trk_idx_s    = best_idx_q;
    if (s2_valid_q) begin
      if (s2_first_q) begin
        trk_best_s   = s2_dist_q;
        trk_idx_s    = s2_idx_q;
        trk_second_s = DIST_MAX;
      end else if (s2_dist_q < best_q) begin
        trk_second_s = best_q;
        trk_best_s   = s2_dist_q;
        trk_idx_s    = s2_idx_q;
      end else if (s2_dist_q < second_q) begin
        trk_second_s = s2_dist_q;
      end else begin
        trk_second_s = second_q;
      end
    end else begin
      trk_best_s = best_q;
    end
    best_d     = trk_best_s;
    second_d   = trk_second_s;
    best_idx_d = trk_idx_s;
  end

  // Stage 3 result: on a last-tagged entry publish the post-update values and the accept decision.
  always_comb begin
    // second >= best always holds, so the plain unsigned difference is exact.
    margin_s     = trk_second_s - trk_best_s;
    valid_d      = 1'b0;
    match_d      = match_q;
    out_idx_d    = out_idx_q;
    out_best_d   = out_best_q;
    out_second_d = out_second_q;
    if (s2_valid_q && s2_last_q) begin
      valid_d      = 1'b1;
      match_d      = (trk_best_s <= s2_max_q) && (margin_s >= s2_margin_q);
      out_idx_d    = trk_idx_s;
      out_best_d   = trk_best_s;
      out_second_d = trk_second_s;
    end else begin
      valid_d = 1'b0;
    end
    drop_d = drop_s;
  end

  // State, pipeline and result registers; reset aborts any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      src_q        <= {DESC_W{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_part_q    <= '0;
      s1_idx_q     <= {IDX_W{1'b0}};
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_max_q     <= {DIST_W{1'b0}};
      s1_margin_q  <= {DIST_W{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_dist_q    <= {DIST_W{1'b0}};
      s2_idx_q     <= {IDX_W{1'b0}};
      s2_first_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_max_q     <= {DIST_W{1'b0}};
      s2_margin_q  <= {DIST_W{1'b0}};
      best_q       <= DIST_MAX;
      second_q     <= DIST_MAX;
      best_idx_q   <= {IDX_W{1'b0}};
      valid_q      <= 1'b0;
      match_q      <= 1'b0;
      out_idx_q    <= {IDX_W{1'b0}};
      out_best_q   <= {DIST_W{1'b0}};
      out_second_q <= {DIST_W{1'b0}};
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      s1_valid_q   <= s1_valid_d;
      s1_part_q    <= s1_part_d;
      s1_idx_q     <= s1_idx_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_max_q     <= s1_max_d;
      s1_margin_q  <= s1_margin_d;
      s2_valid_q   <= s2_valid_d;
      s2_dist_q    <= s2_dist_d;
      s2_idx_q     <= s2_idx_d;
      s2_first_q   <= s2_first_d;
      s2_last_q    <= s2_last_d;
      s2_max_q     <= s2_max_d;
      s2_margin_q  <= s2_margin_d;
      best_q       <= best_d;
      second_q     <= second_d;
      best_idx_q   <= best_idx_d;
      valid_q      <= valid_d;
      match_q      <= match_d;
      out_idx_q    <= out_idx_d;
      out_best_q   <= out_best_d;
      out_second_q <= out_second_d;
      drop_q       <= drop_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_match       = match_q;
  assign o_best_idx    = out_idx_q;
  assign o_best_dist   = out_best_q;
  assign o_second_dist = out_second_q;
  assign o_drop        = drop_q;

endmodule

// File: doc/hamming_best_match.md
Name: hamming_best_match

Overview:
- Streaming brute-force descriptor matcher for the feature-matching stage.
- One source descriptor is matched against a framed burst of candidate descriptors, one candidate per cycle.
- Per candidate: pipelined XOR + popcount Hamming distance.
- Tracks best and second-best distance across the frame, then emits one result with the best index and an accept flag from a distance threshold and a distinctiveness margin test.
- Parametrised successor of the fixed 256-bit two-stage Hamming distance unit.

Parameters:
- DESC_W, 256, descriptor width in bits; power of two, 64..1024.
- IDX_W, 10, width of candidate index.
- DIST_W (localparam), $clog2(DESC_W)+1, distance width; 9 for 256.
- DIST_MAX (localparam), 2**DIST_W-1, "no candidate" sentinel distance.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  candidate beat valid; no backpressure, every valid beat is consumed.
- i_first  in  1  first beat of a frame; qualified by i_valid.
- i_last  in  1  last beat of a frame; qualified by i_valid; may coincide with i_first.
- i_src_desc  in  DESC_W  query descriptor; sampled on the i_first beat only.
- i_dst_desc  in  DESC_W  candidate descriptor.
- i_dst_idx  in  IDX_W  candidate index tag.
- i_max_dist  in  DIST_W  accept threshold; sampled on the i_last beat.
- i_min_margin  in  DIST_W  required second-minus-best margin; sampled on the i_last beat.
- o_valid  out  1  one-cycle result pulse.
- o_match  out  1  accept flag, qualified by o_valid.
- o_best_idx  out  IDX_W  index of the minimum-distance candidate.
- o_best_dist  out  DIST_W  minimum distance.
- o_second_dist  out  DIST_W  second-smallest distance, or DIST_MAX if none.
- o_drop  out  1  one-cycle pulse when a valid beat is discarded.

Behaviour:
- Reset: all outputs 0, frame-open flag 0, pipeline valids 0, best and second registers DIST_MAX. Reset mid-frame aborts the frame and produces no result.
- Source latch:
  - On an i_valid&i_first beat, that beat uses i_src_desc directly and also latches it.
  - Later beats of the frame use the latched value.
- Pipeline, beat accepted in cycle T:
  - S1 (reg at T+1): XOR, then adder tree down to 8 partial sums.
  - S2 (reg at T+2): final sum, registered distance plus idx/first/last tags.
  - S3 (reg at T+3): tracker update; result outputs registered here.
  - o_valid rises in cycle T+3 for the i_last beat.
- Partial sums are widened at each tree level so there is no overflow; distance range is 0..DESC_W.
- Frame FSM, states IDLE and OPEN:
  - IDLE + valid&first&!last: go to OPEN.
  - IDLE + valid&first&last: single-beat frame, stay in IDLE.
  - IDLE + valid&!first: beat dropped, o_drop=1 at T+1, not fed to the pipeline.
  - OPEN + valid&last (no first): go to IDLE.
  - OPEN + valid&first: restart. Pending frame is discarded with no result; o_drop pulses once; the new frame starts with this beat (sets IDLE or OPEN per its last bit).
- Tracker at S3, distance d:
  - If first tag: best=d, best_idx=idx, second=DIST_MAX.
  - Else if d<best: second=best, best=d, best_idx=idx.
  - Else if d<second: second=d.
  - Ties keep the earlier index; strictly-less comparisons only.
- Result on a last-tagged S3 entry, computed from the post-update values:
  - o_match = (best <= max_dist) && ((second - best) >= min_margin).
  - The subtraction is unsigned, DIST_W bits; second >= best always holds.
- Back-to-back frames: a new first beat may follow the last beat in the next cycle. The tracker's first-tag reset prevents bleed between frames. o_valid may pulse on consecutive cycles for consecutive single-beat frames.
- o_best_idx, o_best_dist, o_second_dist and o_match hold their values until the next result.
- o_valid and o_drop are single-cycle pulses.
- Throughput: one candidate per cycle, sustained.

Test Plan:
1. DESC_W=256, src=0, three beats: dst=0xFF, then all-ones, then 0x0F; idx 5,6,7; max_dist=20, margin=2.
   -> Single o_valid 3 cycles after the last beat: best_idx=7, best=4, second=8, match=1.
2. Single-beat frame (first&last), src=0, dst=0x1; max_dist=0.
   -> best=1, second=511, match=0 (threshold fails). Same frame with max_dist=1, margin=0 -> match=1.
3. Tie: distances 10,10,12 on idx 1,2,3; margin=1.
   -> best_idx=1, best=10, second=10, match=0.
4. Four back-to-back single-beat frames, distances 3,0,256,7.
   -> o_valid high on four consecutive cycles with best 3,0,256,7 and second=511 each.
5. Valid beat with no open frame, then first mid-frame after two beats.
   -> o_drop pulses for each. Only the restarted frame yields a result, computed solely from its own beats.
6. Assert i_rst_n low after the 2nd of 4 beats, then release and send a new 2-beat frame.
   -> No result for the aborted frame. Outputs are 0 during reset. The new frame's result is correct at T+3.
